reg_file: RTL

Architectural integer register file with a one-entry registered read stage and a pending-write scoreboard. Sits directly downstream of the register-file read-parameter decode: consumes `reg_file_read_params_t` (rs1, rs2, rd), returns operand data one cycle later to execute, and accepts writeback results. Stalls issue on read-after-write and write-after-write hazards against in-flight writers, with same-cycle writeback bypass.

---
 rtl/reg_file_pkg.sv | 22 ++
 rtl/reg_file_scoreboard.sv | 55 +++++
 rtl/reg_file.sv | 127 ++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and constants for the architectural register file.
package reg_file_pkg;

  localparam int NUM_REGS_ARCH = 32;
  localparam int REG_IDX_W     = $clog2(NUM_REGS_ARCH);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REGISTER_X0 = '0;

  typedef struct packed {
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
  } reg_file_read_params_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus RAW/WAW hazard detection.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_ARCH
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_set_en,
  input  reg_idx_t i_set_idx,
  input  logic     i_wb_valid,
  input  reg_idx_t i_wb_rd,
  input  reg_idx_t i_rs1,
  input  reg_idx_t i_rs2,
  input  reg_idx_t i_rd,
  input  logic     i_writes_rd,
  output logic     o_hazard_rs1,
  output logic     o_hazard_rs2,
  output logic     o_hazard_waw
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_wb_hit_rs1;
  logic                w_wb_hit_rs2;
  logic                w_wb_hit_rd;

  // A new writer claiming rd wins over a writeback retiring the same rd.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_wb_valid && (i_wb_rd != REGISTER_X0)) begin
      w_busy_nxt[i_wb_rd] = 1'b0;
    end
    if (i_set_en && (i_set_idx != REGISTER_X0)) begin
      w_busy_nxt[i_set_idx] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign w_wb_hit_rs1 = i_wb_valid && (i_wb_rd == i_rs1);
  assign w_wb_hit_rs2 = i_wb_valid && (i_wb_rd == i_rs2);
  assign w_wb_hit_rd  = i_wb_valid && (i_wb_rd == i_rd);

  assign o_hazard_rs1 = (i_rs1 != REGISTER_X0) && r_busy[i_rs1] && !w_wb_hit_rs1;
  assign o_hazard_rs2 = (i_rs2 != REGISTER_X0) && r_busy[i_rs2] && !w_wb_hit_rs2;
  assign o_hazard_waw = i_writes_rd && (i_rd != REGISTER_X0) && r_busy[i_rd] && !w_wb_hit_rd;

endmodule

// File: rtl/reg_file.sv
// Architectural register file: storage array, writeback bypass, hazard-gated issue
// and a one-entry registered operand stage.
//   state    | meaning
//   ST_EMPTY | operand stage holds nothing
//   ST_FULL  | operand stage holds data awaiting the consumer
module reg_file
  import reg_file_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = NUM_REGS_ARCH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  reg_file_read_params_t in_params,
  input  logic                  in_writes_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_rs1_data,
  output logic [XLEN-1:0]       out_rs2_data,
  output reg_idx_t              out_rd,
  input  logic                  wb_valid,
  input  reg_idx_t              wb_rd,
  input  logic [XLEN-1:0]       wb_data
);

  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  reg_idx_t        r_rd;
  stage_state_e    r_state;
  stage_state_e    w_state_nxt;

  logic            w_hazard_rs1;
  logic            w_hazard_rs2;
  logic            w_hazard_waw;
  logic            w_accept;
  logic            w_set_en;
  logic            w_wb_hit_rs1;
  logic            w_wb_hit_rs2;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;

  reg_file_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_set_en     (w_set_en),
    .i_set_idx    (in_params.rd),
    .i_wb_valid   (wb_valid),
    .i_wb_rd      (wb_rd),
    .i_rs1        (in_params.rs1),
    .i_rs2        (in_params.rs2),
    .i_rd         (in_params.rd),
    .i_writes_rd  (in_writes_rd),
    .o_hazard_rs1 (w_hazard_rs1),
    .o_hazard_rs2 (w_hazard_rs2),
    .o_hazard_waw (w_hazard_waw)
  );

  assign out_valid = (r_state == ST_FULL);
  assign in_ready  = !w_hazard_rs1 && !w_hazard_rs2 && !w_hazard_waw &&
                     (!out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_set_en  = w_accept && in_writes_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_valid && (wb_rd != REGISTER_X0)) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  assign w_wb_hit_rs1 = wb_valid && (wb_rd == in_params.rs1);
  assign w_wb_hit_rs2 = wb_valid && (wb_rd == in_params.rs2);

  // Same-cycle writeback is forwarded so a stalled reader can issue on that edge.
  always_comb begin
    w_rs1_data = '0;
    w_rs2_data = '0;
    if (in_params.rs1 != REGISTER_X0) begin
      w_rs1_data = w_wb_hit_rs1 ? wb_data : r_regs[in_params.rs1];
    end
    if (in_params.rs2 != REGISTER_X0) begin
      w_rs2_data = w_wb_hit_rs2 ? wb_data : r_regs[in_params.rs2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL:  if (!w_accept && out_ready) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_rd       <= '0;
    end else if (w_accept) begin
      r_rs1_data <= w_rs1_data;
      r_rs2_data <= w_rs2_data;
      r_rd       <= in_params.rd;
    end
  end

  assign out_rs1_data = r_rs1_data;
  assign out_rs2_data = r_rs2_data;
  assign out_rd       = r_rd;

endmodule
